// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target: FSM state encodings and the address-match helper.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        k_t_idle      = 3'd0,
        k_t_addr      = 3'd1,
        k_t_addr_ack  = 3'd2,
        k_t_rx_data   = 3'd3,
        k_t_rx_ack    = 3'd4,
        k_t_tx_data   = 3'd5,
        k_t_tx_ack    = 3'd6,
        k_t_wait_stop = 3'd7
    } target_state_e;

    localparam logic [2:0] k_last_bit = 3'd7;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return addr_byte[7:1] == own_addr;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronisers with one extra registered copy used to detect SCL edges and START/STOP.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_raw,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_d_reg;
    logic                   sda_d_reg;
    logic                   scl_s;

    // Preset to 1 so an idle bus out of reset never looks like an edge or a START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_d_reg    <= 1'b1;
            sda_d_reg    <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
            scl_d_reg    <= scl_s;
            sda_d_reg    <= sda_s;
        end
    end

    assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d_reg;
    assign scl_fall  = ~scl_s & scl_d_reg;
    assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
    assign stop_raw  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

endmodule

// File: rtl/i2c_target.sv
// Oversampled I2C target: address match, write bytes with ACK, read bytes served from tx_data.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       addr_hit,
    output logic       rw,
    output logic       stop_det,
    output logic       busy
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_raw;
    logic sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_raw (stop_raw),
        .sda_s    (sda_s)
    );

    target_state_e state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] tx_buf_reg, tx_buf_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       phase_reg, phase_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       tx_req_reg, tx_req_next;
    logic       addr_hit_reg, addr_hit_next;
    logic       rw_reg, rw_next;
    logic       stop_det_reg, stop_det_next;
    logic       busy_reg, busy_next;
    logic       matched_reg, matched_next;

    logic [7:0] rx_byte;
    logic       byte_done;

    assign rx_byte   = {shift_reg[6:0], sda_s};
    assign byte_done = (bit_cnt_reg == k_last_bit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= k_t_idle;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            tx_buf_reg   <= 8'h00;
            rx_data_reg  <= 8'h00;
            phase_reg    <= 1'b0;
            sda_oe_reg   <= 1'b0;
            rx_valid_reg <= 1'b0;
            tx_req_reg   <= 1'b0;
            addr_hit_reg <= 1'b0;
            rw_reg       <= 1'b0;
            stop_det_reg <= 1'b0;
            busy_reg     <= 1'b0;
            matched_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_buf_reg   <= tx_buf_next;
            rx_data_reg  <= rx_data_next;
            phase_reg    <= phase_next;
            sda_oe_reg   <= sda_oe_next;
            rx_valid_reg <= rx_valid_next;
            tx_req_reg   <= tx_req_next;
            addr_hit_reg <= addr_hit_next;
            rw_reg       <= rw_next;
            stop_det_reg <= stop_det_next;
            busy_reg     <= busy_next;
            matched_reg  <= matched_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start_det) begin
            state_next = k_t_addr;
        end else if (stop_raw) begin
            state_next = k_t_idle;
        end else begin
            case (state_reg)
                k_t_idle: state_next = k_t_idle;
                k_t_addr: begin
                    if (scl_rise && byte_done)
                        state_next = addr_match(rx_byte, ADDR) ? k_t_addr_ack : k_t_wait_stop;
                end
                k_t_addr_ack: begin
                    if (scl_fall && phase_reg)
                        state_next = rw_reg ? k_t_tx_data : k_t_rx_data;
                end
                k_t_rx_data: begin
                    if (scl_rise && byte_done)
                        state_next = k_t_rx_ack;
                end
                k_t_rx_ack: begin
                    if (scl_fall && phase_reg)
                        state_next = k_t_rx_data;
                end
                k_t_tx_data: begin
                    if (scl_fall && bit_cnt_reg == 3'd0)
                        state_next = k_t_tx_ack;
                end
                k_t_tx_ack: begin
                    if (scl_rise && sda_s)
                        state_next = k_t_wait_stop;
                    else if (scl_fall && phase_reg)
                        state_next = k_t_tx_data;
                end
                k_t_wait_stop: state_next = k_t_wait_stop;
                default:       state_next = k_t_idle;
            endcase
        end
    end

    always_comb begin
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        tx_buf_next   = tx_req_reg ? tx_data : tx_buf_reg;
        rx_data_next  = rx_data_reg;
        phase_next    = phase_reg;
        sda_oe_next   = sda_oe_reg;
        rx_valid_next = 1'b0;
        tx_req_next   = 1'b0;
        addr_hit_next = 1'b0;
        rw_next       = rw_reg;
        stop_det_next = 1'b0;
        busy_next     = busy_reg;
        matched_next  = matched_reg;

        if (start_det) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = 3'd0;
            busy_next    = 1'b1;
            matched_next = 1'b0;
            phase_next   = 1'b0;
        end else if (stop_raw) begin
            sda_oe_next   = 1'b0;
            busy_next     = 1'b0;
            stop_det_next = matched_reg;
            matched_next  = 1'b0;
            phase_next    = 1'b0;
        end else begin
            case (state_reg)
                k_t_addr: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (byte_done && addr_match(rx_byte, ADDR)) begin
                            rw_next       = rx_byte[0];
                            addr_hit_next = 1'b1;
                            matched_next  = 1'b1;
                            phase_next    = 1'b0;
                        end
                    end
                end
                // phase 0: waiting for the fall that opens the ACK slot; phase 1: ACK driven
                k_t_addr_ack, k_t_rx_ack: begin
                    if (scl_rise && phase_reg && state_reg == k_t_addr_ack && rw_reg)
                        tx_req_next = 1'b1;
                    if (scl_fall) begin
                        if (!phase_reg) begin
                            sda_oe_next = 1'b1;
                            phase_next  = 1'b1;
                        end else begin
                            phase_next = 1'b0;
                            if (state_reg == k_t_addr_ack && rw_reg) begin
                                shift_next  = tx_buf_reg;
                                sda_oe_next = ~tx_buf_reg[7];
                            end else begin
                                sda_oe_next = 1'b0;
                            end
                        end
                    end
                end
                k_t_rx_data: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (byte_done) begin
                            rx_data_next  = rx_byte;
                            rx_valid_next = 1'b1;
                            phase_next    = 1'b0;
                        end
                    end
                end
                // bit 7 is already on the line; each fall presents the next bit from shift[6]
                k_t_tx_data: begin
                    if (scl_rise)
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (scl_fall) begin
                        if (bit_cnt_reg == 3'd0) begin
                            sda_oe_next = 1'b0;
                            phase_next  = 1'b0;
                        end else begin
                            sda_oe_next = ~shift_reg[6];
                            shift_next  = {shift_reg[6:0], 1'b0};
                        end
                    end
                end
                k_t_tx_ack: begin
                    if (scl_rise && !sda_s) begin
                        tx_req_next = 1'b1;
                        phase_next  = 1'b1;
                    end
                    if (scl_fall && phase_reg) begin
                        shift_next  = tx_buf_reg;
                        sda_oe_next = ~tx_buf_reg[7];
                        phase_next  = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign tx_req   = tx_req_reg;
    assign addr_hit = addr_hit_reg;
    assign rw       = rw_reg;
    assign stop_det = stop_det_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Bench: bit-banged I2C controller plus a transaction-level model of the target's responses.
module tb_i2c_target;

    localparam int         Q      = 6;
    localparam logic [6:0] ADDR_T = 7'h50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_ctrl;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       addr_hit;
    logic       rw;
    logic       stop_det;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int rx_cnt = 0, tx_cnt = 0, hit_cnt = 0, stop_cnt = 0, oe_cnt = 0;
    logic [7:0] rx_log[$];
    logic [7:0] tx_q[$];
    logic [7:0] pay_q[$];

    always #5 clk = ~clk;

    assign sda_line = sda_ctrl & ~sda_oe;

    i2c_target #(
        .ADDR       (7'h50),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .addr_hit(addr_hit),
        .rw      (rw),
        .stop_det(stop_det),
        .busy    (busy)
    );

    // Monitor: pulse counters, received-byte log, and the read-data supplier.
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_data = 8'h00;
        end else begin
            if (rx_valid) begin
                rx_cnt++;
                rx_log.push_back(rx_data);
            end
            if (tx_req) begin
                tx_cnt++;
                if (tx_q.size() > 0) tx_data = tx_q.pop_front();
            end
            if (addr_hit) hit_cnt++;
            if (stop_det) stop_cnt++;
            if (sda_oe) oe_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q;
        repeat (Q) @(negedge clk);
    endtask

    task automatic when_start;
        sda_ctrl = 1'b1; wait_q;
        scl = 1'b1;      wait_q;
        sda_ctrl = 1'b0; wait_q;
        scl = 1'b0;      wait_q;
    endtask

    task automatic when_stop;
        sda_ctrl = 1'b0; wait_q;
        scl = 1'b1;      wait_q;
        sda_ctrl = 1'b1; wait_q;
    endtask

    task automatic when_bit(input logic b, output logic seen);
        sda_ctrl = b; wait_q;
        scl = 1'b1;   wait_q;
        seen = sda_line; wait_q;
        scl = 1'b0;   wait_q;
    endtask

    task automatic when_send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) when_bit(b[i], dummy);
        when_bit(1'b1, ack);
    endtask

    task automatic when_recv_byte(input logic nack, output logic [7:0] b);
        logic bit_v;
        logic dummy;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            when_bit(1'b1, bit_v);
            b = {b[6:0], bit_v};
        end
        when_bit(nack, dummy);
    endtask

    // One complete transfer from START to STOP with payload from pay_q.
    task automatic then_xfer(input logic [7:0] ab);
        int rx0, tx0, hit0, stop0, oe0, n;
        logic ack;
        logic hit;
        logic [7:0] got;
        logic [7:0] exp_q[$];
        n = pay_q.size();
        hit = (ab[7:1] == ADDR_T);
        rx_log.delete();
        tx_q.delete();
        if (hit && ab[0]) for (int i = 0; i < n; i++) tx_q.push_back(pay_q[i]);
        rx0 = rx_cnt; tx0 = tx_cnt; hit0 = hit_cnt; stop0 = stop_cnt; oe0 = oe_cnt;
        $display("xfer addr=%02h n=%0d hit=%0d", ab, n, hit);
        when_start;
        when_send_byte(ab, ack);
        check_eq("addr_ack", {31'd0, ack}, {31'd0, ~hit});
        check_eq("busy_mid", {31'd0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if (hit && ab[0]) begin
                when_recv_byte(i == n - 1, got);
                check_eq("rd_byte", {24'd0, got}, {24'd0, pay_q[i]});
            end else begin
                when_send_byte(pay_q[i], ack);
                check_eq("data_ack", {31'd0, ack}, {31'd0, ~hit});
                if (hit) exp_q.push_back(pay_q[i]);
            end
        end
        when_stop;
        wait_q;
        check_eq("busy_end", {31'd0, busy}, 32'd0);
        check_eq("sda_oe_end", {31'd0, sda_oe}, 32'd0);
        check_eq("hit_cnt", hit_cnt - hit0, {31'd0, hit});
        check_eq("stop_cnt", stop_cnt - stop0, {31'd0, hit});
        check_eq("rx_cnt", rx_cnt - rx0, exp_q.size());
        check_eq("tx_cnt", tx_cnt - tx0, (hit && ab[0]) ? n : 0);
        if (hit) check_eq("rw", {31'd0, rw}, {31'd0, ab[0]});
        else     check_eq("oe_never", oe_cnt - oe0, 32'd0);
        while (exp_q.size() > 0 && rx_log.size() > 0)
            check_eq("rx_data", {24'd0, rx_log.pop_front()}, {24'd0, exp_q.pop_front()});
        pay_q.delete();
    endtask

    task automatic then_outputs_reset(input string tag);
        check_eq({tag, "_oe"},   {31'd0, sda_oe},   32'd0);
        check_eq({tag, "_rxd"},  {24'd0, rx_data},  32'd0);
        check_eq({tag, "_rxv"},  {31'd0, rx_valid}, 32'd0);
        check_eq({tag, "_txr"},  {31'd0, tx_req},   32'd0);
        check_eq({tag, "_hit"},  {31'd0, addr_hit}, 32'd0);
        check_eq({tag, "_rw"},   {31'd0, rw},       32'd0);
        check_eq({tag, "_stop"}, {31'd0, stop_det}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy},     32'd0);
    endtask

    initial begin
        logic ack, dummy;
        logic [7:0] got, ab;
        int rx0, tx0, stop0, hit0;

        rst_n = 1'b0; scl = 1'b1; sda_ctrl = 1'b1;
        repeat (4) @(negedge clk);
        then_outputs_reset("reset");
        rst_n = 1'b1;
        wait_q;

        pay_q = '{8'h3C};       then_xfer(8'hA0);
        pay_q = '{8'h96, 8'h5A}; then_xfer(8'hA1);
        pay_q = '{8'h55};       then_xfer(8'hA2);
        pay_q = '{8'h00, 8'hFF}; then_xfer(8'hA1);
        pay_q = '{8'h12};       then_xfer(8'h00);

        // Write then repeated START into a read.
        $display("xfer rstart write 11 read C3");
        rx_log.delete(); tx_q.delete(); tx_q.push_back(8'hC3);
        rx0 = rx_cnt; tx0 = tx_cnt; stop0 = stop_cnt; hit0 = hit_cnt;
        when_start;
        when_send_byte(8'hA0, ack);
        when_send_byte(8'h11, ack);
        check_eq("rs_wr_ack", {31'd0, ack}, 32'd0);
        when_start;
        when_send_byte(8'hA1, ack);
        check_eq("rs_rd_ack", {31'd0, ack}, 32'd0);
        when_recv_byte(1'b1, got);
        check_eq("rs_rd_byte", {24'd0, got}, 32'hC3);
        when_stop;
        wait_q;
        check_eq("rs_rxd", {24'd0, rx_data}, 32'h11);
        check_eq("rs_rw", {31'd0, rw}, 32'd1);
        check_eq("rs_rx_cnt", rx_cnt - rx0, 32'd1);
        check_eq("rs_tx_cnt", tx_cnt - tx0, 32'd1);
        check_eq("rs_hit_cnt", hit_cnt - hit0, 32'd2);
        check_eq("rs_stop_cnt", stop_cnt - stop0, 32'd1);

        // STOP after four data bits.
        $display("xfer midbyte stop");
        rx0 = rx_cnt; stop0 = stop_cnt;
        when_start;
        when_send_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) when_bit(i[0], dummy);
        when_stop;
        wait_q;
        check_eq("mid_rx_cnt", rx_cnt - rx0, 32'd0);
        check_eq("mid_oe", {31'd0, sda_oe}, 32'd0);
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_stop_cnt", stop_cnt - stop0, 32'd1);

        // Reset while the address ACK is being driven.
        $display("xfer reset during ack");
        when_start;
        ab = 8'hA1;
        for (int i = 7; i >= 0; i--) when_bit(ab[i], dummy);
        check_eq("rst_ack_oe", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        then_outputs_reset("rst_ack");
        @(negedge clk);
        rst_n = 1'b1;
        sda_ctrl = 1'b1; scl = 1'b1;
        wait_q; wait_q;

        for (int t = 0; t < 20; t++) begin
            int n;
            case ($urandom_range(0, 3))
                0: ab = 8'hA0;
                1: ab = 8'hA1;
                2: ab = {7'h50 ^ 7'($urandom_range(1, 127)), 1'($urandom)};
                default: ab = 8'($urandom);
            endcase
            n = ab[0] ? $urandom_range(1, 3) : $urandom_range(0, 3);
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            then_xfer(ab);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
Clock-oversampled I2C target (slave) that responds to the controller-side state machine's bus transactions. It synchronises SCL/SDA and detects START, repeated START and STOP. It matches a 7-bit address, receives write bytes with ACK, and serves read bytes from a user interface. SDA is driven open-drain through an output-enable, and the block never drives SCL (no clock stretching).

Parameters:
ADDR, 7'h50, 7-bit target address to match.
SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in, minimum 2.

Ports:
clk  input  1  system clock; the bus is sampled only on posedge clk.
rst_n  input  1  synchronous active-low reset.
scl_in  input  1  raw SCL pin level.
sda_in  input  1  raw SDA pin level.
sda_oe  output  1  1 = pull SDA low, 0 = release; pad drives 0 when set.
rx_data  output  8  last byte received in a write transfer.
rx_valid  output  1  one-cycle pulse when rx_data updates.
tx_req  output  1  one-cycle pulse requesting the next read byte.
tx_data  input  8  read byte; latched on the clk cycle after tx_req.
addr_hit  output  1  one-cycle pulse on address match.
rw  output  1  R/W bit of the current matched transfer (1 = read).
stop_det  output  1  one-cycle pulse on STOP while addressed.
busy  output  1  1 from START until STOP.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state = IDLE; sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, addr_hit=0, rw=0, stop_det=0, busy=0.
  - Synchronisers preset to 1.
  - Reset mid-transfer releases SDA on the next edge.
- Front end:
  - SYNC_STAGES sync, plus one registered copy for edge detection.
  - Pin-to-event latency = SYNC_STAGES+1 clk.
  - SCL high and low times must each be at least SYNC_STAGES+2 clk.
- Events, on synchronised signals:
  - START = SDA fall while SCL high; STOP = SDA rise while SCL high.
  - rise = SCL 0->1; fall = SCL 1->0.
  - START has priority over everything else.
- Rules:
  - Bits are sampled on rise, MSB first.
  - sda_oe changes only on fall or on START/STOP/reset.
- States, shared with the controller constants:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on rise.
    - After the 8th rise, compare bits[7:1] with ADDR.
    - Match: latch rw, pulse addr_hit, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP.
  - ADDR_ACK: on first fall set sda_oe=1.
    - rw=0: on the next fall clear sda_oe, go to RX_DATA.
    - rw=1: pulse tx_req on the ACK rise; on the next fall latch tx_data into the shift register, drive bit 7 (sda_oe=~bit), go to TX_DATA.
  - RX_DATA: shift 8 bits.
    - On the 8th rise, rx_data <= shift and pulse rx_valid.
    - Go to RX_ACK; ACK is always given.
  - RX_ACK: same ACK timing as ADDR_ACK, then return to RX_DATA.
  - TX_DATA: on each fall present the next bit.
    - After the 8th bit's fall, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on rise.
    - 0 (ACK): pulse tx_req at that rise, then on fall load and drive bit 7 and go to TX_DATA.
    - 1 (NACK): go to WAIT_STOP; SDA stays released.
  - WAIT_STOP: SDA released; ignore bits until START or STOP.
- START/STOP handling:
  - START from any state (repeated START): sda_oe=0, bit count=0, go to ADDR, busy=1.
  - STOP from any state: sda_oe=0, go to IDLE, busy=0.
  - stop_det pulses only if an address matched since the last START.
- Bit counter is 3 bits, wraps 7->0 at the byte boundary.
- Read bytes of 8'h00/8'hFF are legal; a NACKed byte is not requested again.
- General call (address 0) is not acknowledged unless ADDR=0.

Decomposition:
- Target state encodings (k_t_idle, k_t_addr, k_t_addr_ack, k_t_rx_data, k_t_rx_ack, k_t_tx_data, k_t_tx_ack, k_t_wait_stop) go in include/i2c.vh alongside the existing controller states.
- One sub-module, i2c_bus_sync: synchronisers plus edge/START/STOP detection, outputs scl_rise, scl_fall, start_det, stop_raw, sda_s.
- The test bench reuses the shared step-task style (when_/then_ steps).

Test Plan:
- Write 0xA0 (addr 0x50 W), then 0x3C, then STOP -> addr_hit=1, rw=0; ACK low during 9th SCL of both bytes; rx_data=8'h3C with one rx_valid pulse; stop_det=1; busy=0.
- Read 0xA1 with tx_data=8'h96, controller ACKs, then tx_data=8'h5A, controller NACKs, then STOP -> SDA bits 1,0,0,1,0,1,1,0 then 0,1,0,1,1,0,1,0; exactly 2 tx_req pulses; SDA released after NACK.
- Address 0xA2 (0x51 W) -> no addr_hit, sda_oe stays 0 for the whole transfer, rx_valid never pulses.
- Write 0xA0, 0x11, repeated START, 0xA1, read 8'hC3 with NACK -> rx_data=8'h11, then rw=1 and 8'hC3 on SDA.
- STOP issued mid-byte after 4 bits of a write -> state IDLE, sda_oe=0, no rx_valid.
- rst_n=0 while driving the ACK -> sda_oe=0 and all outputs at reset values on the following clk.
